// File: rtl/softmax_bram_pkg.sv
// Purpose: shared types, default widths and word-split helper for the BRAM-to-softmax sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package softmax_bram_pkg;

    localparam int DATA_W_DEF = 1024;
    localparam int MODE_W_DEF = 4;
    localparam int ADDR_W_DEF = 5;

    // Widest {mode, data} word and widest mode field the split helper handles.
    localparam int WORD_W_MAX = 2048;
    localparam int MODE_W_MAX = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    // Extracts the mode field sitting above the data field of a packed BRAM word.
    // data_w is an elaboration-time constant at every call site, so the shift is static.
    function automatic logic [MODE_W_MAX-1:0] word_mode(input logic [WORD_W_MAX-1:0] word,
                                                        input int                    data_w);
        logic [WORD_W_MAX-1:0] shifted;
        shifted = word >> data_w;
        return shifted[MODE_W_MAX-1:0];
    endfunction

endpackage

// File: rtl/softmax_mode_fifo.sv
// Purpose: synchronous FIFO carrying each row's mode bits from read side to write side.
// Latency: first-word fall-through; a pushed entry is visible at head_dat the next cycle.
// Backpressure: push ignored when full, pop ignored when empty; en=0 freezes all state.
// Ports: clk/rst_n (sync active-low), en, push/push_dat, pop, head_dat, empty, full.
module softmax_mode_fifo #(
    parameter int WIDTH = 4,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty,
    output logic             full
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok;
    logic             pop_ok;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok  = en && push && !full;
    assign pop_ok   = en && pop && !empty;
    assign head_dat = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: emptiness is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/softmax_bram_seq.sv
// Purpose: streams a programmable block of BRAM rows (port B) into the softmax core and writes results back (port A).
// Latency: one row read per cycle; o_valid trails o_cenb by RD_LAT; each write lands 1 cycle after i_valid.
// Backpressure: none toward softmax; unexpected i_valid is dropped and flagged on o_err; i_en=0 freezes everything.
// Ports: i_clk, i_rst_n (sync active-low), i_en, i_start + i_src_base/i_dst_base/i_num_rows job setup,
//        o_busy/o_done/o_err status, port A (o_cena/o_wea/o_addra/o_dina), port B (o_cenb/o_addrb/i_doutb),
//        softmax side (o_valid/o_length_mode/o_in_x_flat out, i_valid/i_prob_flat in).
module softmax_bram_seq
    import softmax_bram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int MODE_W = MODE_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int RD_LAT = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic                     i_start,
    input  logic [ADDR_W-1:0]        i_src_base,
    input  logic [ADDR_W-1:0]        i_dst_base,
    input  logic [ADDR_W:0]          i_num_rows,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err,
    output logic                     o_cena,
    output logic                     o_wea,
    output logic [ADDR_W-1:0]        o_addra,
    output logic [MODE_W+DATA_W-1:0] o_dina,
    output logic                     o_cenb,
    output logic [ADDR_W-1:0]        o_addrb,
    input  logic [MODE_W+DATA_W-1:0] i_doutb,
    output logic                     o_valid,
    output logic [MODE_W-1:0]        o_length_mode,
    output logic [DATA_W-1:0]        o_in_x_flat,
    input  logic                     i_valid,
    input  logic [DATA_W-1:0]        i_prob_flat
);

    localparam int WORD_W = MODE_W + DATA_W;
    localparam int CNT_W  = ADDR_W + 1;

    seq_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   src_base_q, src_base_d;
    logic [ADDR_W-1:0]   dst_base_q, dst_base_d;
    logic [CNT_W-1:0]    num_rows_q, num_rows_d;
    logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
    logic                err_q, err_d;
    logic                cena_q, cena_d;
    logic [ADDR_W-1:0]   addra_q, addra_d;
    logic [WORD_W-1:0]   dina_q, dina_d;
    logic [RD_LAT-1:0]   vld_pipe_q, vld_pipe_d;

    logic                busy;
    logic                wr_acc;
    logic                fifo_push;
    logic                fifo_empty;
    logic                fifo_full;
    logic [MODE_W-1:0]   fifo_head;

    assign busy   = (state_q == READ) || (state_q == DRAIN);
    // A result is only consumed when a job expects it and its mode bits are already queued.
    assign wr_acc = i_valid && busy && (wr_cnt_q < num_rows_q) && !fifo_empty;

    assign o_busy        = busy;
    assign o_done        = (state_q == DONE);
    assign o_err         = err_q;
    assign o_cena        = cena_q;
    assign o_wea         = cena_q;
    assign o_addra       = addra_q;
    assign o_dina        = dina_q;
    assign o_cenb        = (state_q == READ);
    assign o_addrb       = src_base_q + rd_cnt_q[ADDR_W-1:0];
    assign o_valid       = vld_pipe_q[RD_LAT-1];
    assign o_length_mode = MODE_W'(word_mode(WORD_W_MAX'(i_doutb), DATA_W));
    assign o_in_x_flat   = i_doutb[DATA_W-1:0];

    assign fifo_push = o_valid && !fifo_full;

    softmax_mode_fifo #(
        .WIDTH (MODE_W),
        .AW    (ADDR_W)
    ) u_mode_fifo (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .en       (i_en),
        .push     (fifo_push),
        .push_dat (o_length_mode),
        .pop      (wr_acc),
        .head_dat (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    always_comb begin
        state_d    = state_q;
        src_base_d = src_base_q;
        dst_base_d = dst_base_q;
        num_rows_d = num_rows_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        err_d      = err_q;
        cena_d     = 1'b0;
        addra_d    = addra_q;
        dina_d     = dina_q;
        // Shift-left form works for every RD_LAT >= 1, including a single stage.
        vld_pipe_d = (vld_pipe_q << 1) | RD_LAT'(o_cenb);

        if (wr_acc) begin
            cena_d   = 1'b1;
            addra_d  = dst_base_q + wr_cnt_q[ADDR_W-1:0];
            dina_d   = {fifo_head, i_prob_flat};
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end else if (i_valid) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    src_base_d = i_src_base;
                    dst_base_d = i_dst_base;
                    num_rows_d = i_num_rows;
                    rd_cnt_d   = '0;
                    wr_cnt_d   = '0;
                    err_d      = 1'b0;
                    state_d    = (i_num_rows == '0) ? DONE : READ;
                end
            end
            READ: begin
                rd_cnt_d = rd_cnt_q + CNT_W'(1);
                if (rd_cnt_q == num_rows_q - CNT_W'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Looking at the updated count lets DONE coincide with the final write strobe.
                if (wr_cnt_d == num_rows_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            src_base_q <= '0;
            dst_base_q <= '0;
            num_rows_q <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            err_q      <= 1'b0;
            cena_q     <= 1'b0;
            addra_q    <= '0;
            dina_q     <= '0;
            vld_pipe_q <= '0;
        end else if (i_en) begin
            state_q    <= state_d;
            src_base_q <= src_base_d;
            dst_base_q <= dst_base_d;
            num_rows_q <= num_rows_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            err_q      <= err_d;
            cena_q     <= cena_d;
            addra_q    <= addra_d;
            dina_q     <= dina_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

endmodule

// File: tb/tb_softmax_bram_seq.sv
// Purpose: directed self-checking bench for softmax_bram_seq with a BRAM model and a softmax model.
// Latency: BRAM model reads in 2 cycles; softmax model answers roughly 5 cycles after o_valid.
// Backpressure: both models share the DUT enable.
module tb_softmax_bram_seq;

    localparam int DW     = 16;
    localparam int MW     = 4;
    localparam int AW     = 5;
    localparam int WW     = MW + DW;
    localparam int SM_LAT = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          start;
    logic [AW-1:0] src_base;
    logic [AW-1:0] dst_base;
    logic [AW:0]   num_rows;
    logic          o_busy, o_done, o_err, o_cena, o_wea, o_cenb, o_valid;
    logic [AW-1:0] o_addra, o_addrb;
    logic [WW-1:0] o_dina;
    logic [WW-1:0] doutb;
    logic [MW-1:0] o_length_mode;
    logic [DW-1:0] o_in_x_flat;
    logic          i_valid;
    logic [DW-1:0] i_prob;

    logic          sm_vld;
    logic [DW-1:0] sm_prob;
    logic          inj_vld;
    logic [DW-1:0] inj_prob;
    bit            gap_mode;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign i_valid = sm_vld | inj_vld;
    assign i_prob  = inj_vld ? inj_prob : sm_prob;

    softmax_bram_seq #(
        .DATA_W (DW),
        .MODE_W (MW),
        .ADDR_W (AW),
        .RD_LAT (2)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_en          (en),
        .i_start       (start),
        .i_src_base    (src_base),
        .i_dst_base    (dst_base),
        .i_num_rows    (num_rows),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_err         (o_err),
        .o_cena        (o_cena),
        .o_wea         (o_wea),
        .o_addra       (o_addra),
        .o_dina        (o_dina),
        .o_cenb        (o_cenb),
        .o_addrb       (o_addrb),
        .i_doutb       (doutb),
        .o_valid       (o_valid),
        .o_length_mode (o_length_mode),
        .o_in_x_flat   (o_in_x_flat),
        .i_valid       (i_valid),
        .i_prob_flat   (i_prob)
    );

    // ---------------- BRAM model: two-stage read pipe, write on port A ----------------
    logic [WW-1:0] mem [0:31];
    logic [WW-1:0] rp0, rp1;

    always @(posedge clk) begin
        if (!rst_n) begin
            rp0 <= '0;
            rp1 <= '0;
        end else if (en) begin
            rp0 <= o_cenb ? mem[o_addrb] : '0;
            rp1 <= rp0;
            if (o_cena && o_wea) mem[o_addra] <= o_dina;
        end
    end
    assign doutb = rp1;

    // ---------------- softmax model: result = ~x, in order, optional 1-on/2-off gaps ----------------
    logic [DW-1:0] smq_x[$];
    int            smq_due[$];
    int            mcyc;

    always @(posedge clk) begin
        if (!rst_n) begin
            smq_x.delete();
            smq_due.delete();
            mcyc = 0;
            sm_vld  <= 1'b0;
            sm_prob <= '0;
        end else if (en) begin
            mcyc = mcyc + 1;
            if (o_valid) begin
                smq_x.push_back(o_in_x_flat);
                smq_due.push_back(mcyc + SM_LAT);
            end
            if (smq_x.size() > 0 && smq_due[0] <= mcyc && (!gap_mode || (mcyc % 3) == 0)) begin
                sm_vld  <= 1'b1;
                sm_prob <= ~smq_x[0];
                smq_x.pop_front();
                smq_due.pop_front();
            end else begin
                sm_vld <= 1'b0;
            end
        end
    end

    // ---------------- monitor (negedge, enabled cycles only) ----------------
    int            rd_log[$];
    int            wr_addr_log[$];
    logic [WW-1:0] wr_dat_log[$];
    int            done_cnt, done_with_wr, done_busy_fall;
    bit            prev_busy = 1'b0;

    always @(negedge clk) begin
        if (rst_n && en) begin
            if (o_cenb) rd_log.push_back(int'(o_addrb));
            if (o_cena && o_wea) begin
                wr_addr_log.push_back(int'(o_addra));
                wr_dat_log.push_back(o_dina);
            end
            if (o_done) begin
                done_cnt++;
                if (o_cena && o_wea) done_with_wr++;
                if (!o_busy && prev_busy) done_busy_fall++;
            end
            prev_busy = o_busy;
        end
    end

    logic [DW-1:0] exp_x    [0:31];
    logic [MW-1:0] exp_mode [0:31];

    task automatic clear_logs();
        rd_log.delete();
        wr_addr_log.delete();
        wr_dat_log.delete();
        done_cnt       = 0;
        done_with_wr   = 0;
        done_busy_fall = 0;
    endtask

    task automatic load_rows(input int src, input int rows, input int mode_off);
        for (int i = 0; i < rows; i++) begin
            exp_x[i]    = DW'(16'h1000 + i * 16'h0111 + src * 3);
            exp_mode[i] = MW'(i + mode_off);
            mem[(src + i) % 32] <= {exp_mode[i], exp_x[i]};
        end
        @(posedge clk);
    endtask

    task automatic do_start(input int src, input int dst, input int rows);
        @(posedge clk); #1;
        start    = 1'b1;
        src_base = AW'(src);
        dst_base = AW'(dst);
        num_rows = (AW+1)'(rows);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (o_done) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
    endtask

    // Counts mismatches of the logged traffic against the expected job; 1000 flags a wrong count.
    task automatic collect_job(input int src, input int dst, input int rows,
                               output int rd_bad, output int wr_bad);
        logic [WW-1:0] w;
        rd_bad = 0;
        wr_bad = 0;
        if (rd_log.size() != rows) rd_bad = 1000;
        else for (int i = 0; i < rows; i++) if (rd_log[i] != (src + i) % 32) rd_bad++;
        if (wr_addr_log.size() != rows) wr_bad = 1000;
        else for (int i = 0; i < rows; i++) begin
            w = {exp_mode[i], ~exp_x[i]};
            if (wr_addr_log[i] != (dst + i) % 32 || wr_dat_log[i] !== w) wr_bad++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; start = 1'b0; inj_vld = 1'b0; inj_prob = '0;
        src_base = '0; dst_base = '0; num_rows = '0; gap_mode = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({o_busy, o_done, o_err, o_cena, o_wea, o_cenb, o_valid} !== 7'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 0000000",
                {o_busy, o_done, o_err, o_cena, o_wea, o_cenb, o_valid});
        end
        n_chk++;
        if ({o_addra, o_addrb} !== '0) begin
            n_fail++; $display("FAIL reset_addr: got addra=%0d addrb=%0d expected 0/0", o_addra, o_addrb);
        end
        n_chk++;
        if (o_dina !== '0) begin
            n_fail++; $display("FAIL reset_dina: got %h expected 0", o_dina);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        bit ok; int rd_bad, wr_bad;
        load_rows(0, 12, 3);
        clear_logs();
        do_start(0, 12, 12);
        wait_done(300, ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL basic_done_timeout: got no o_done expected o_done within 300 cycles"); end
        collect_job(0, 12, 12, rd_bad, wr_bad);
        n_chk++;
        if (rd_bad != 0) begin n_fail++; $display("FAIL basic_reads: got %0d bad (count %0d) expected 0", rd_bad, rd_log.size()); end
        n_chk++;
        if (wr_bad != 0) begin n_fail++; $display("FAIL basic_writes: got %0d bad (count %0d) expected 0", wr_bad, wr_addr_log.size()); end
        n_chk++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
        n_chk++;
        if (done_busy_fall != 1) begin n_fail++; $display("FAIL basic_busy_fall: got %0d expected 1", done_busy_fall); end
        n_chk++;
        if (done_with_wr != 1) begin n_fail++; $display("FAIL basic_done_with_last_write: got %0d expected 1", done_with_wr); end
    endtask

    task automatic test_wrap();
        bit ok; int rd_bad, wr_bad;
        load_rows(28, 6, 0);
        clear_logs();
        do_start(28, 30, 6);
        wait_done(300, ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL wrap_done_timeout: got no o_done expected o_done within 300 cycles"); end
        collect_job(28, 30, 6, rd_bad, wr_bad);
        n_chk++;
        if (rd_bad != 0) begin n_fail++; $display("FAIL wrap_reads: got %0d bad expected 0", rd_bad); end
        n_chk++;
        if (wr_bad != 0) begin n_fail++; $display("FAIL wrap_writes: got %0d bad expected 0", wr_bad); end
        if (wr_dat_log.size() == 6) begin
            n_chk++;
            if (wr_dat_log[5][WW-1:DW] !== 4'd5 || wr_addr_log[5] != 3) begin
                n_fail++; $display("FAIL wrap_last_row: got mode=%0d addr=%0d expected 5/3",
                    wr_dat_log[5][WW-1:DW], wr_addr_log[5]);
            end
        end
    endtask

    task automatic test_gapped();
        bit ok; int rd_bad, wr_bad;
        gap_mode = 1'b1;
        load_rows(0, 8, 7);
        clear_logs();
        do_start(0, 16, 8);
        wait_done(400, ok);
        gap_mode = 1'b0;
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL gap_done_timeout: got no o_done expected o_done within 400 cycles"); end
        collect_job(0, 16, 8, rd_bad, wr_bad);
        n_chk++;
        if (wr_bad != 0) begin n_fail++; $display("FAIL gap_writes: got %0d bad (count %0d) expected 0", wr_bad, wr_addr_log.size()); end
        n_chk++;
        if (done_cnt != 1 || done_with_wr != 1) begin
            n_fail++; $display("FAIL gap_drain_hold: got done=%0d done_with_write=%0d expected 1/1", done_cnt, done_with_wr);
        end
    endtask

    task automatic test_zero_rows();
        clear_logs();
        @(posedge clk); #1;
        start = 1'b1; src_base = 5'd3; dst_base = 5'd9; num_rows = '0;
        @(negedge clk);
        n_chk++;
        if (o_done !== 1'b0) begin n_fail++; $display("FAIL zero_done_early: got %b expected 0", o_done); end
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        n_chk++;
        if (o_done !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL zero_done_pulse: got done=%b busy=%b expected 1/0", o_done, o_busy);
        end
        @(negedge clk);
        n_chk++;
        if (o_done !== 1'b0) begin n_fail++; $display("FAIL zero_done_width: got %b expected 0", o_done); end
        repeat (5) @(negedge clk);
        n_chk++;
        if (rd_log.size() != 0 || wr_addr_log.size() != 0) begin
            n_fail++; $display("FAIL zero_bram_idle: got reads=%0d writes=%0d expected 0/0", rd_log.size(), wr_addr_log.size());
        end
    endtask

    task automatic test_err();
        clear_logs();
        @(posedge clk); #1;
        inj_vld = 1'b1; inj_prob = 16'hBEEF;
        @(posedge clk); #1;
        inj_vld = 1'b0;
        @(negedge clk);
        n_chk++;
        if (o_err !== 1'b1 || o_cena !== 1'b0) begin
            n_fail++; $display("FAIL err_set: got err=%b cena=%b expected 1/0", o_err, o_cena);
        end
        do_start(0, 0, 0);
        @(negedge clk);
        n_chk++;
        if (o_err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b expected 0", o_err); end
        repeat (3) @(negedge clk);
        n_chk++;
        if (wr_addr_log.size() != 0) begin n_fail++; $display("FAIL err_no_write: got %0d writes expected 0", wr_addr_log.size()); end
    endtask

    task automatic test_reset_freeze();
        bit ok; int rd_bad, wr_bad;
        load_rows(0, 12, 1);
        clear_logs();
        do_start(0, 12, 12);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_chk++;
        if ({o_busy, o_done, o_err, o_cena, o_wea, o_cenb, o_valid} !== 7'b0 ||
            o_addra !== '0 || o_addrb !== '0 || o_dina !== '0) begin
            n_fail++; $display("FAIL midjob_reset: got flags=%b addra=%0d addrb=%0d dina=%h expected all 0",
                {o_busy, o_done, o_err, o_cena, o_wea, o_cenb, o_valid}, o_addra, o_addrb, o_dina);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_logs();
        repeat (20) @(negedge clk);
        n_chk++;
        if (rd_log.size() != 0 || wr_addr_log.size() != 0) begin
            n_fail++; $display("FAIL abort_quiet: got reads=%0d writes=%0d expected 0/0", rd_log.size(), wr_addr_log.size());
        end

        load_rows(0, 4, 9);
        clear_logs();
        do_start(0, 20, 4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_chk++;
            if ({o_busy, o_cenb, o_valid, o_cena} !== 4'b1110 || o_addrb !== 5'd2 || o_length_mode !== exp_mode[0]) begin
                n_fail++; $display("FAIL freeze_%0d: got busy/cenb/valid/cena=%b addrb=%0d mode=%0d expected 1110/2/%0d",
                    k, {o_busy, o_cenb, o_valid, o_cena}, o_addrb, o_length_mode, exp_mode[0]);
            end
            @(posedge clk);
        end
        #1 en = 1'b1;
        wait_done(300, ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL freeze_done_timeout: got no o_done expected o_done within 300 cycles"); end
        collect_job(0, 20, 4, rd_bad, wr_bad);
        n_chk++;
        if (rd_bad != 0 || wr_bad != 0) begin
            n_fail++; $display("FAIL freeze_job: got rd_bad=%0d wr_bad=%0d expected 0/0", rd_bad, wr_bad);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_gapped();
        test_zero_rows();
        test_err();
        test_reset_freeze();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected completion before 500000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
